pipeline_execute_unit: RTL

//  - EX stage datapath plus EX/MEM pipeline register; consumes ID/EX register outputs (E-suffix signals).
//  - Forwarding muxes, ALU, branch compare, jump/branch target, PC redirect; registers results into MEM (M-suffix).
//  - Sits between the ID/EX register and the data-memory stage; the hazard unit drives forward selects, stall and flush.

---
 rtl/pipeline_execute_unit_pkg.sv | 59 +++++
 rtl/pipeline_execute_unit_alu.sv | 61 ++++++
 rtl/pipeline_execute_unit.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pipeline_execute_unit_pkg.sv
// Shared EX-stage definitions: data width, ALU opcodes, branch funct3 codes,
// forward-select encodings and the EX/MEM register payload.
`ifndef XLEN
`define XLEN 32
`endif

package pipeline_execute_unit_pkg;

    localparam int unsigned XLEN       = `XLEN;
    localparam int unsigned SHAMT_W    = 5;
    localparam int unsigned REG_ADDR_W = 5;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_SLL = 3'b110;
    localparam logic [2:0] ALU_SRL = 3'b111;

    localparam logic [2:0] BR_EQ  = 3'b000;
    localparam logic [2:0] BR_NE  = 3'b001;
    localparam logic [2:0] BR_LT  = 3'b100;
    localparam logic [2:0] BR_GE  = 3'b101;
    localparam logic [2:0] BR_LTU = 3'b110;
    localparam logic [2:0] BR_GEU = 3'b111;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef struct packed {
        logic                  reg_wr_en;
        logic [1:0]            result_src;
        logic                  mem_wr_en;
        logic [3:0]            mem_byte_sel;
        logic [2:0]            funct3;
        logic [XLEN-1:0]       alu_result;
        logic [XLEN-1:0]       write_data;
        logic [XLEN-1:0]       pc_plus4;
        logic [REG_ADDR_W-1:0] rd_addr;
    } ex_mem_t;

    // Select 11 aliases the register-file path.
    function automatic logic [XLEN-1:0] fwd_mux(input logic [1:0]      sel,
                                                input logic [XLEN-1:0] rf,
                                                input logic [XLEN-1:0] wb,
                                                input logic [XLEN-1:0] mem);
        logic [XLEN-1:0] res;
        case (sel)
            FWD_WB:  res = wb;
            FWD_MEM: res = mem;
            default: res = rf;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/pipeline_execute_unit_alu.sv
// Combinational ALU plus branch-condition compare for the EX stage.
module pipeline_alu
    import pipeline_execute_unit_pkg::*;
(
    input  logic [XLEN-1:0] src_a_i,
    input  logic [XLEN-1:0] src_b_i,
    input  logic [XLEN-1:0] cmp_b_i,
    input  logic [2:0]      alu_ctrl_i,
    input  logic            alu_sra_i,
    input  logic [2:0]      funct3_i,
    output logic [XLEN-1:0] result_c_o,
    output logic            cond_c_o
);

    logic [SHAMT_W-1:0]     shamt;
    logic signed [XLEN-1:0] sra_res;
    logic                   slt_s;
    logic                   slt_u;
    logic                   cmp_eq;
    logic                   cmp_lt_s;
    logic                   cmp_lt_u;

    always_comb begin
        shamt   = src_b_i[SHAMT_W-1:0];
        sra_res = $signed(src_a_i) >>> shamt;
        slt_s   = $signed(src_a_i) < $signed(src_b_i);
        slt_u   = src_a_i < src_b_i;

        result_c_o = '0;
        case (alu_ctrl_i)
            ALU_ADD: result_c_o = src_a_i + src_b_i;
            ALU_SUB: result_c_o = src_a_i - src_b_i;
            ALU_AND: result_c_o = src_a_i & src_b_i;
            ALU_OR:  result_c_o = src_a_i | src_b_i;
            ALU_XOR: result_c_o = src_a_i ^ src_b_i;
            ALU_SLT: result_c_o = XLEN'(funct3_i[0] ? slt_u : slt_s);
            ALU_SLL: result_c_o = src_a_i << shamt;
            ALU_SRL: result_c_o = alu_sra_i ? XLEN'(sra_res) : (src_a_i >> shamt);
            default: result_c_o = '0;
        endcase
    end

    // Branches compare against the forwarded rs2, never the immediate.
    always_comb begin
        cmp_eq   = src_a_i == cmp_b_i;
        cmp_lt_s = $signed(src_a_i) < $signed(cmp_b_i);
        cmp_lt_u = src_a_i < cmp_b_i;

        cond_c_o = 1'b0;
        case (funct3_i)
            BR_EQ:   cond_c_o = cmp_eq;
            BR_NE:   cond_c_o = !cmp_eq;
            BR_LT:   cond_c_o = cmp_lt_s;
            BR_GE:   cond_c_o = !cmp_lt_s;
            BR_LTU:  cond_c_o = cmp_lt_u;
            BR_GEU:  cond_c_o = !cmp_lt_u;
            default: cond_c_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/pipeline_execute_unit.sv
// EX stage: operand forwarding, ALU, branch/jump redirect and the EX/MEM register.
// Optional performance counters are built when RV32_EX_PERF_EN is defined.
module pipeline_execute_unit
    import pipeline_execute_unit_pkg::*;
#(
    parameter int unsigned PERF_CNT_W = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_stall,
    input  logic                  i_flush,
    input  logic [1:0]            i_fwd_a_sel,
    input  logic [1:0]            i_fwd_b_sel,
    input  logic [XLEN-1:0]       i_resultW,
    input  logic                  i_ctrl_reg_wr_enE,
    input  logic [1:0]            i_ctrl_result_srcE,
    input  logic                  i_ctrl_mem_wr_enE,
    input  logic                  i_ctrl_jalE,
    input  logic                  i_ctrl_jalrE,
    input  logic                  i_ctrl_branchE,
    input  logic [2:0]            i_ctrl_alu_ctrlE,
    input  logic                  i_ctrl_alu_srcE,
    input  logic                  i_ctrl_alu_sraE,
    input  logic [3:0]            i_ctrl_mem_byte_selE,
    input  logic [2:0]            i_ctrl_funct3E,
    input  logic [XLEN-1:0]       i_rs1_dataE,
    input  logic [XLEN-1:0]       i_rs2_dataE,
    input  logic [XLEN-1:0]       i_PCE,
    input  logic [XLEN-1:0]       i_ExtImmE,
    input  logic [XLEN-1:0]       i_PCPlus4E,
    input  logic [REG_ADDR_W-1:0] i_rd_addrE,
    output logic                  o_redirect_en,
    output logic [XLEN-1:0]       o_redirect_pc,
    output logic                  o_ctrl_reg_wr_enM,
    output logic [1:0]            o_ctrl_result_srcM,
    output logic                  o_ctrl_mem_wr_enM,
    output logic [3:0]            o_ctrl_mem_byte_selM,
    output logic [2:0]            o_ctrl_funct3M,
    output logic [XLEN-1:0]       o_alu_resultM,
    output logic [XLEN-1:0]       o_write_dataM,
    output logic [XLEN-1:0]       o_PCPlus4M,
    output logic [REG_ADDR_W-1:0] o_rd_addrM,
    output logic [PERF_CNT_W-1:0] o_perf_branch_cnt,
    output logic [PERF_CNT_W-1:0] o_perf_taken_cnt
);

    ex_mem_t         ex_mem_d;
    ex_mem_t         ex_mem_q;
    logic [XLEN-1:0] src_a;
    logic [XLEN-1:0] src_b_fwd;
    logic [XLEN-1:0] src_b;
    logic [XLEN-1:0] alu_result;
    logic            branch_cond;
    logic            is_jump;

    always_comb begin
        src_a     = fwd_mux(i_fwd_a_sel, i_rs1_dataE, i_resultW, ex_mem_q.alu_result);
        src_b_fwd = fwd_mux(i_fwd_b_sel, i_rs2_dataE, i_resultW, ex_mem_q.alu_result);
        src_b     = i_ctrl_alu_srcE ? i_ExtImmE : src_b_fwd;
        is_jump   = i_ctrl_jalE | i_ctrl_jalrE;
    end

    pipeline_alu u_alu (
        .src_a_i    (src_a),
        .src_b_i    (src_b),
        .cmp_b_i    (src_b_fwd),
        .alu_ctrl_i (i_ctrl_alu_ctrlE),
        .alu_sra_i  (i_ctrl_alu_sraE),
        .funct3_i   (i_ctrl_funct3E),
        .result_c_o (alu_result),
        .cond_c_o   (branch_cond)
    );

    // Misaligned targets pass through untouched; only jalr clears bit 0.
    always_comb begin
        o_redirect_pc = i_ctrl_jalrE ? ((src_a + i_ExtImmE) & ~XLEN'(1))
                                     : (i_PCE + i_ExtImmE);
        o_redirect_en = !i_stall & (is_jump | (i_ctrl_branchE & branch_cond));
    end

    always_comb begin
        ex_mem_d              = '0;
        ex_mem_d.reg_wr_en    = i_ctrl_reg_wr_enE;
        ex_mem_d.result_src   = i_ctrl_result_srcE;
        ex_mem_d.mem_wr_en    = i_ctrl_mem_wr_enE;
        ex_mem_d.mem_byte_sel = i_ctrl_mem_byte_selE;
        ex_mem_d.funct3       = i_ctrl_funct3E;
        ex_mem_d.alu_result   = is_jump ? i_PCPlus4E : alu_result;
        ex_mem_d.write_data   = src_b_fwd;
        ex_mem_d.pc_plus4     = i_PCPlus4E;
        ex_mem_d.rd_addr      = i_rd_addrE;
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            ex_mem_q <= '0;
        end else if (i_flush) begin
            ex_mem_q <= '0;
        end else if (!i_stall) begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign o_ctrl_reg_wr_enM    = ex_mem_q.reg_wr_en;
    assign o_ctrl_result_srcM   = ex_mem_q.result_src;
    assign o_ctrl_mem_wr_enM    = ex_mem_q.mem_wr_en;
    assign o_ctrl_mem_byte_selM = ex_mem_q.mem_byte_sel;
    assign o_ctrl_funct3M       = ex_mem_q.funct3;
    assign o_alu_resultM        = ex_mem_q.alu_result;
    assign o_write_dataM        = ex_mem_q.write_data;
    assign o_PCPlus4M           = ex_mem_q.pc_plus4;
    assign o_rd_addrM           = ex_mem_q.rd_addr;

`ifdef RV32_EX_PERF_EN
    logic [PERF_CNT_W-1:0] branch_cnt_q;
    logic [PERF_CNT_W-1:0] taken_cnt_q;

    // Counts survive flushes; only stalled cycles are skipped.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            branch_cnt_q <= '0;
            taken_cnt_q  <= '0;
        end else if (!i_stall && i_ctrl_branchE) begin
            branch_cnt_q <= branch_cnt_q + PERF_CNT_W'(1);
            if (branch_cond) begin
                taken_cnt_q <= taken_cnt_q + PERF_CNT_W'(1);
            end
        end
    end

    assign o_perf_branch_cnt = branch_cnt_q;
    assign o_perf_taken_cnt  = taken_cnt_q;
`else
    assign o_perf_branch_cnt = '0;
    assign o_perf_taken_cnt  = '0;
`endif

endmodule
